cdb_arbiter: RTL



---
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-unit result FIFOs feeding a round-robin grant onto a
// registered write-back bus that the register file, RS and forwarding logic snoop.
module cdb_arbiter #(
    parameter int unsigned UNIT_NUM    = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH   = 5,
    parameter int unsigned TAG_INVALID = 31,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [UNIT_NUM-1:0]            ex_valid,
    input  logic [UNIT_NUM*TAG_WIDTH-1:0]  ex_tag,
    input  logic [UNIT_NUM*DATA_WIDTH-1:0] ex_data,
    output logic [UNIT_NUM-1:0]            ex_ready,
    output logic                           wb_valid,
    output logic [TAG_WIDTH-1:0]           wb_tag,
    output logic [DATA_WIDTH-1:0]          wb_data,
    output logic [$clog2(UNIT_NUM)-1:0]    wb_src
);

    localparam int unsigned SRC_W = $clog2(UNIT_NUM);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [TAG_WIDTH-1:0]  r_tag_mem  [UNIT_NUM][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [UNIT_NUM][FIFO_DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr   [UNIT_NUM];
    logic [PTR_W-1:0]      r_wr_ptr   [UNIT_NUM];
    logic [CNT_W-1:0]      r_count    [UNIT_NUM];
    logic [SRC_W-1:0]      r_last_grant;

    logic                  r_wb_valid;
    logic [TAG_WIDTH-1:0]  r_wb_tag;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [SRC_W-1:0]      r_wb_src;

    logic [UNIT_NUM-1:0]   w_push;
    logic [UNIT_NUM-1:0]   w_pop;
    logic [UNIT_NUM-1:0]   w_eligible;
    logic                  w_any;
    logic [SRC_W-1:0]      w_winner;
    logic [SRC_W-1:0]      w_idx;

    assign wb_valid = r_wb_valid;
    assign wb_tag   = r_wb_tag;
    assign wb_data  = r_wb_data;
    assign wb_src   = r_wb_src;

    // Ready depends on registered count only: a full FIFO stays not-ready even while popping.
    always_comb begin
        ex_ready   = '0;
        w_eligible = '0;
        w_push     = '0;
        for (int i = 0; i < int'(UNIT_NUM); i++) begin
            ex_ready[i]   = r_count[i] < CNT_W'(FIFO_DEPTH);
            w_eligible[i] = r_count[i] != '0;
            w_push[i]     = ex_valid[i] & ex_ready[i] & ~rst & ~flush;
        end
    end

    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= int'(UNIT_NUM); k++) begin
            w_idx = SRC_W'((int'(r_last_grant) + k) % int'(UNIT_NUM));
            if (!w_any && w_eligible[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(UNIT_NUM); i++) begin
            w_pop[i] = w_any & ~rst & ~flush & (w_winner == SRC_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(UNIT_NUM); i++) begin
            if (w_push[i]) begin
                r_tag_mem[i][r_wr_ptr[i]]  <= ex_tag[i*TAG_WIDTH +: TAG_WIDTH];
                r_data_mem[i][r_wr_ptr[i]] <= ex_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(UNIT_NUM); i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_wb_valid   <= 1'b0;
            r_wb_tag     <= TAG_WIDTH'(TAG_INVALID);
            r_wb_data    <= '0;
            r_wb_src     <= '0;
            r_last_grant <= SRC_W'(UNIT_NUM - 1);
        end else begin
            for (int i = 0; i < int'(UNIT_NUM); i++) begin
                if (flush) begin
                    r_rd_ptr[i] <= '0;
                    r_wr_ptr[i] <= '0;
                    r_count[i]  <= '0;
                end else begin
                    if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                    if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                    if (w_push[i] && !w_pop[i]) begin
                        r_count[i] <= r_count[i] + 1'b1;
                    end else if (w_pop[i] && !w_push[i]) begin
                        r_count[i] <= r_count[i] - 1'b1;
                    end
                end
            end
            // Flush keeps wb_src and last_grant so arbitration resumes where it left off.
            if (flush || !w_any) begin
                r_wb_valid <= 1'b0;
                r_wb_tag   <= TAG_WIDTH'(TAG_INVALID);
                r_wb_data  <= '0;
            end else begin
                r_wb_valid   <= 1'b1;
                r_wb_tag     <= r_tag_mem[w_winner][r_rd_ptr[w_winner]];
                r_wb_data    <= r_data_mem[w_winner][r_rd_ptr[w_winner]];
                r_wb_src     <= w_winner;
                r_last_grant <= w_winner;
            end
        end
    end

endmodule
